bcd_counter_display: RTL and testbench

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

---
 rtl/bcd_counter_display.sv | 148 ++++++++++++++
 tb/tb_bcd_counter_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_display
// Brief    : 4-digit up/down BCD counter stepped on synchronised clk_div rising
//            edges, with a time-multiplexed active-low 7-segment scan driver.
// Revision : 1.0
// ============================================================================
module bcd_counter_display #(
  parameter int REFRESH_COUNT = 50000,
  parameter int BLANK_LZ      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic        tick,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int               REF_W    = $clog2(REFRESH_COUNT);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_COUNT - 1);

  logic             s1_q, s1_d, s2_q, s2_d, p_q, p_d;
  logic [15:0]      count_q, count_d, count_step;
  logic             tick_q, tick_d;
  logic [REF_W-1:0] refresh_q, refresh_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             div_rise, step, carry, ref_wrap;
  logic [3:0]       digit, lz;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Ripple the +1/-1 through the digits; carry/borrow stops at the first digit that does not wrap.
  always_comb begin
    count_step = count_q;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (up) begin
          if (count_q[4*i +: 4] >= 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    s1_d     = clk_div;
    s2_d     = s1_q;
    p_d      = s2_q;
    div_rise = s2_q & ~p_q;
    step     = div_rise & en & ~clr;
    tick_d   = step;
    if (clr) begin
      count_d = 16'h0000;
    end else if (step) begin
      count_d = count_step;
    end else begin
      count_d = count_q;
    end
  end

  always_comb begin
    ref_wrap  = (refresh_q == REF_LAST);
    refresh_d = ref_wrap ? '0 : refresh_q + REF_W'(1);
    sel_d     = ref_wrap ? sel_q + 2'd1 : sel_q;
  end

  // Decode from the next-state count and select so an/seg load together and match count_bcd.
  always_comb begin
    lz    = 4'b0000;
    lz[1] = (count_d[15:4] == 12'd0);
    lz[2] = (count_d[15:8] == 8'd0);
    lz[3] = (count_d[15:12] == 4'd0);
    digit = 4'd0;
    case (sel_d)
      2'd0: digit = count_d[3:0];
      2'd1: digit = count_d[7:4];
      2'd2: digit = count_d[11:8];
      2'd3: digit = count_d[15:12];
      default: digit = 4'd0;
    endcase
    an_d  = ~(4'b0001 << sel_d);
    seg_d = ((BLANK_LZ != 0) && lz[sel_d]) ? 7'b1111111 : seg_decode(digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      p_q       <= 1'b0;
      count_q   <= 16'h0000;
      tick_q    <= 1'b0;
      refresh_q <= '0;
      sel_q     <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= 7'b1000000;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      p_q       <= p_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign tick      = tick_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_display.sv
`default_nettype none
// Scoreboard bench: random clk_div pulses drive an integer count model; a negedge
// monitor pops expected steps when tick appears, display checked from cycle counts.
module tb_bcd_counter_display;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clk_div = 1'b0, en = 1'b0, up = 1'b1, clr = 1'b0;
  logic [15:0] cnt_a, cnt_b;
  logic        tick_a, tick_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int errors = 0, checks = 0;
  int cyc = 0, nrst = 0, model = 0;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_counter_display #(.REFRESH_COUNT(R), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .clk_div(clk_div), .en(en), .up(up), .clr(clr),
    .count_bcd(cnt_a), .tick(tick_a), .an(an_a), .seg(seg_a));

  bcd_counter_display #(.REFRESH_COUNT(R), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .clk_div(clk_div), .en(en), .up(up), .clr(clr),
    .count_bcd(cnt_b), .tick(tick_b), .an(an_b), .seg(seg_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) if (rst) nrst <= 0; else nrst <= nrst + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One clk_div period starting at posedge+1; a qualifying rise is due as a step 3 edges later.
  task automatic pulse();
    exp_t e;
    int   hi, lo;
    hi = $urandom_range(2, 4);
    lo = $urandom_range(2, 4);
    clk_div = 1'b1;
    if (en && !clr) begin
      model = up ? (model + 1) % 10000 : (model + 9999) % 10000;
      e.val = to_bcd(model);
      e.at  = cyc + 3;
      sb.push_back(e);
    end
    repeat (hi) next();
    clk_div = 1'b0;
    repeat (lo) next();
  endtask

  task automatic pulses(input int n);
    repeat (n) pulse();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    next();
    clr = 1'b0;
    model = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    model = 0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic chk_count(input string name);
    chk({name, "_a"}, cnt_a, to_bcd(model));
    chk({name, "_b"}, cnt_b, to_bcd(model));
  endtask

  // Scan position follows purely from edges since reset release; count is static here.
  task automatic chk_display(input int n);
    int         s, d;
    logic [3:0] ea;
    logic [6:0] es;
    repeat (n) begin
      next();
      s  = (nrst / R) % 4;
      d  = (model / (10 ** s)) % 10;
      ea = ~(4'b0001 << s);
      es = seg_tab[d];
      chk("an_a", an_a, ea);
      chk("seg_a", seg_a, es);
      chk("an_b", an_b, ea);
      chk("seg_b", seg_b, (s > 0 && model < 10 ** s) ? 7'b1111111 : es);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_tick;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_tick: no tick by cycle %0d, required step to %h", e.at, e.val);
      end
      exp_tick = (sb.size() > 0 && sb[0].at == cyc);
      if (tick_a || tick_b || exp_tick) begin
        checks++;
        if (tick_a !== exp_tick || tick_b !== exp_tick) begin
          errors++;
          $display("FAIL tick: got a=%b b=%b at cycle %0d, required %b", tick_a, tick_b, cyc, exp_tick);
        end
        if (exp_tick) begin
          e = sb.pop_front();
          checks++;
          if (cnt_a !== e.val || cnt_b !== e.val) begin
            errors++;
            $display("FAIL step_count: got a=%h b=%h, required %h", cnt_a, cnt_b, e.val);
          end
        end
      end
    end
  end

  initial begin
    apply_reset();
    chk_count("reset_count");
    chk("reset_tick", {tick_a, tick_b}, 2'b00);
    chk("reset_an", {an_a, an_b}, {4'b1110, 4'b1110});
    chk("reset_seg", {seg_a, seg_b}, {7'b1000000, 7'b1000000});

    en = 1'b1; up = 1'b1;
    pulses(12);
    chk_count("count12");

    do_clear();
    chk_count("clear_idle");
    up = 1'b0; pulse(); chk_count("wrap_down");
    up = 1'b1; pulse(); chk_count("wrap_up");
    up = 1'b0; pulse(); chk_count("wrap_down2");

    do_clear();
    up = 1'b1;
    pulses(45);
    chk_count("count45");
    // clr lands in the same cycle the synchronised rise is seen
    clk_div = 1'b1;
    next(); next();
    clr = 1'b1;
    next();
    clr = 1'b0;
    model = 0;
    chk("clr_edge_tick", {tick_a, tick_b}, 2'b00);
    chk_count("clr_edge_count");
    repeat (2) next();
    clk_div = 1'b0;
    repeat (3) next();

    pulses(7);
    en = 1'b0;
    pulses(5);
    chk_count("en_off");
    en = 1'b1;
    pulse();
    chk_count("en_back");

    for (int i = 0; i < 30; i++) begin
      en = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 1) == 1);
      pulses($urandom_range(1, 4));
      chk_count("random");
    end

    apply_reset();
    en = 1'b1; up = 1'b1;
    pulses(1234);
    chk_count("count1234");
    chk_display(20);
    do_clear();
    pulses(5);
    chk_display(20);
    pulses(45);
    chk_display(20);

    // asynchronous reset mid-scan and mid-synchronisation
    repeat (5) next();
    clk_div = 1'b1;
    next(); next();
    #2;
    rst = 1'b1;
    sb.delete();
    model = 0;
    #1;
    chk("midrst_an", {an_a, an_b}, {4'b1110, 4'b1110});
    chk("midrst_seg", {seg_a, seg_b}, {7'b1000000, 7'b1000000});
    chk("midrst_tick", {tick_a, tick_b}, 2'b00);
    chk_count("midrst_count");
    clk_div = 1'b0;
    next();
    rst = 1'b0;
    repeat (8) next();
    chk_count("pending_discard");

    // clk_div already high when reset releases counts as one rise
    rst = 1'b1;
    clk_div = 1'b1;
    next();
    rst = 1'b0;
    begin
      exp_t e;
      model = 1;
      e.val = to_bcd(model);
      e.at  = cyc + 3;
      sb.push_back(e);
    end
    repeat (3) next();
    clk_div = 1'b0;
    repeat (4) next();
    chk_count("release_high");

    repeat (6) next();
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
